lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store initiator between the CPU memory stage and a word-organised, handshaked data-memory port.
- Accepts byte, half and word load/store requests using the CPU's DataWidth encoding.
- Issues one or two aligned word transactions with byte enables; an access that crosses a word boundary is split into two.
- Merges and sign- or zero-extends read data, then returns a single response to the CPU.

Parameters:
- ADDR_W, 32, address width in bits.
- IO_BASE, 32'hBFC01000, first address of the I/O window; at or above it, accesses are never split and use byte enables 4'b1111.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  CPU request valid.
- req_ready  output  1  initiator can accept a request.
- req_wen  input  1  1 = store, 0 = load.
- req_width  input  3  000 W, 001 H, 010 B, 101 HU, 110 BU; other codes are treated as W.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  one-cycle pulse: load data valid, or store completed.
- rsp_rdata  output  32  extended load data; 0 for stores.
- mem_req  output  1  memory transaction request.
- mem_gnt  input  1  memory accepts the transaction in this cycle.
- mem_addr  output  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_wen  output  1  write transaction.
- mem_be  output  4  byte enables, little-endian lanes.
- mem_wdata  output  32  lane-shifted write data.
- mem_rvalid  input  1  read data returned.
- mem_rdata  input  32  read data.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, mem_req=0, mem_wen=0, mem_be=0, mem_addr=0, mem_wdata=0. FSM state = IDLE; all internal registers cleared.
- Reset asserted mid-transaction aborts it; no response is produced, and any late mem_rvalid is ignored after reset.
- FSM states: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP.
- IDLE, req_ready=1:
  - req_valid&&req_ready registers the request and goes to ISSUE1.
  - req_ready is 0 in every other state.
  - At most one CPU request is in flight.
- Access decode, from size s (1, 2 or 4) and offset o=addr[1:0]:
  - Split when o+s>4 and addr < IO_BASE.
  - First beat: address addr&~3, lanes o..min(o+s,4)-1.
  - Second beat: address (addr&~3)+4, lanes 0..o+s-5.
  - The second-beat address wraps modulo 2^ADDR_W, so 0xFFFFFFFC+4 -> 0x00000000.
- Write data is rotated left by 8*o bits; byte i of the data lands in lane (o+i) mod 4.
- ISSUE1 / ISSUE2:
  - mem_req=1, with mem_addr, mem_wen, mem_be and mem_wdata held stable until mem_gnt.
  - On the granting cycle, mem_req drops the following cycle.
  - Store beat: go to ISSUE2 if split, else RESP.
  - Load beat: go to WAIT1 or WAIT2 respectively.
- WAIT1 / WAIT2:
  - On mem_rvalid, capture the enabled lanes into a 4-byte assembly register at byte positions (lane-o) mod 4.
  - Then go to ISSUE2 if split and in WAIT1, else RESP.
  - mem_rvalid in a cycle where no read is outstanding is ignored.
  - mem_rvalid may arrive at the earliest one cycle after the grant.
- RESP:
  - rsp_valid=1 for exactly one cycle; the FSM then returns to IDLE.
  - rsp_rdata: W = all 4 bytes; H/B = sign-extended from bit 15/7; HU/BU = zero-extended.
- Latency (request accept to rsp_valid), with immediate grant and one-cycle rvalid:
  - aligned store: 2 cycles.
  - aligned load: 3 cycles.
  - split store: 3 cycles.
  - split load: 5 cycles.
- mem_be is never 0 while mem_req=1.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Adds output port misalign_err, 1 bit, reset 0.
  - A request with o+s>4 issues no memory transaction; RESP follows the next cycle.
  - rsp_valid=1, misalign_err=1 and rsp_rdata=0 in that cycle; misalign_err is otherwise 0.
- Macro undefined: no such port; misaligned accesses are split as described under Behaviour.

Test Plan:
- Aligned LW at 0x00010000, memory returns 0xDEADBEEF, immediate gnt -> one transaction with be=1111; rsp_valid at cycle 3 with rsp_rdata=0xDEADBEEF.
- SB 0x000000A5 to 0x00010003 -> mem_addr=0x00010000, be=1000, mem_wdata[31:24]=0xA5; rsp_valid at cycle 2.
- LH at 0x00010003, word@0x10000=0x80xxxxxx (lane 3 = 0x80) and word@0x10004=0xxxxxxx12 (lane 0 = 0x12):
  - first beat be=1000, second beat 0x00010004 be=0001.
  - rsp_rdata=0x00001280; with LHU and lane 0 = 0x92, rsp_rdata=0x00009280, and LH gives 0xFFFF9280.
- SW 0x11223344 to 0xFFFFFFFE below IO_BASE (IO_BASE overridden to 0) -> beats at 0xFFFFFFFC be=1100 wdata[31:16]=0x3344, then 0x00000000 be=0011 wdata[15:0]=0x1122.
- Grant withheld 5 cycles on an LB -> mem_req, mem_addr and mem_be stable throughout, req_ready=0; rsp_valid only after rvalid. rst_n pulsed low in WAIT1 -> all outputs return to reset values, and no rsp_valid follows.
- With MISALIGN_TRAP_EN, LW at 0x00010002 -> mem_req stays 0; next-cycle rsp_valid=1, misalign_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one CPU byte/half/word request into one or two aligned,
// handshaked word transactions and returns a merged, extended response. Optional MISALIGN_TRAP_EN.
module lsu_mem_initiator #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'hBFC01000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_width,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign_err
`endif
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP} state_t;

  state_t            state, state_nxt;
  logic              wen_q, sign_q, split_q, trap_q;
  logic [2:0]        size_q;
  logic [1:0]        off_q;
  logic [3:0]        be1_q, be2_q;
  logic [ADDR_W-1:0] word_q;
  logic [31:0]       wdata_q, asm_q, asm_nxt;

  // Request decode, evaluated combinationally on the accepting cycle.
  logic        accept;
  logic [2:0]  req_size;
  logic        req_sign;
  logic [3:0]  req_mask;
  logic [3:0]  req_end;
  logic [7:0]  be_span;
  logic        req_io, req_split;
  logic [63:0] wdata_dbl;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    req_size = 3'd4;
    req_mask = 4'b1111;
    req_sign = 1'b0;
    case (req_width)
      3'b001: begin req_size = 3'd2; req_mask = 4'b0011; req_sign = 1'b1; end
      3'b101: begin req_size = 3'd2; req_mask = 4'b0011; end
      3'b010: begin req_size = 3'd1; req_mask = 4'b0001; req_sign = 1'b1; end
      3'b110: begin req_size = 3'd1; req_mask = 4'b0001; end
      default: ;
    endcase
  end

  assign req_end   = {2'b00, req_addr[1:0]} + {1'b0, req_size};
  // IO_BASE of zero means the design has no I/O window at all.
  assign req_io    = (IO_BASE != '0) && (req_addr >= IO_BASE);
  assign req_split = (req_end > 4'd4) && !req_io;
  assign be_span   = {4'b0000, req_mask} << req_addr[1:0];
  assign wdata_dbl = {req_wdata, req_wdata} << {req_addr[1:0], 3'b000};

  // Position in the assembly register of a byte that arrived on a given lane.
  function automatic logic [1:0] lane_pos(input logic [1:0] lane, input logic [1:0] off);
    return lane - off;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = (TRAP_EN && req_split) ? RESP : ISSUE1;
      ISSUE1: if (mem_gnt) state_nxt = !wen_q ? WAIT1 : (split_q ? ISSUE2 : RESP);
      WAIT1:  if (mem_rvalid) state_nxt = split_q ? ISSUE2 : RESP;
      ISSUE2: if (mem_gnt) state_nxt = wen_q ? RESP : WAIT2;
      WAIT2:  if (mem_rvalid) state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    asm_nxt = asm_q;
    if (accept) begin
      asm_nxt = '0;
    end else if (mem_rvalid && (state == WAIT1 || state == WAIT2)) begin
      for (int l = 0; l < 4; l++) begin
        if ((state == WAIT1) ? be1_q[l] : be2_q[l])
          asm_nxt[8*lane_pos(2'(l), off_q) +: 8] = mem_rdata[8*l +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the assembly register is reset too; a load aborted by reset must leave no stale bytes behind.
      state   <= IDLE;
      wen_q   <= 1'b0;
      sign_q  <= 1'b0;
      split_q <= 1'b0;
      trap_q  <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      be1_q   <= 4'd0;
      be2_q   <= 4'd0;
      word_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
    end else begin
      state <= state_nxt;
      asm_q <= asm_nxt;
      if (accept) begin
        wen_q   <= req_wen;
        sign_q  <= req_sign;
        split_q <= req_split;
        trap_q  <= TRAP_EN && req_split;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
        be1_q   <= req_io ? 4'b1111 : be_span[3:0];
        be2_q   <= be_span[7:4];
        word_q  <= {req_addr[ADDR_W-1:2], 2'b00};
        wdata_q <= wdata_dbl[63:32];
      end
    end
  end

  // Memory-side outputs are driven only while a beat is being offered.
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_be    = 4'd0;
    mem_wdata = '0;
    if (state == ISSUE1 || state == ISSUE2) begin
      mem_req   = 1'b1;
      mem_wen   = wen_q;
      mem_wdata = wdata_q;
      mem_addr  = (state == ISSUE1) ? word_q : word_q + ADDR_W'(4);
      mem_be    = (state == ISSUE1) ? be1_q : be2_q;
    end
  end

  always_comb begin
    rsp_rdata = '0;
    if (state == RESP && !wen_q && !trap_q) begin
      case (size_q)
        3'd1:    rsp_rdata = {{24{sign_q & asm_q[7]}}, asm_q[7:0]};
        3'd2:    rsp_rdata = {{16{sign_q & asm_q[15]}}, asm_q[15:0]};
        default: rsp_rdata = asm_q;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

`ifdef MISALIGN_TRAP_EN
  assign misalign_err = (state == RESP) && trap_q;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed vector table plus hand sequences for
// grant back-pressure, reset abort and address wrap. Also builds with MISALIGN_TRAP_EN.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wen;
  logic [2:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        misal;

  // Second instance with no I/O window, used for the address-wrap store.
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_mem_req, f_mem_gnt, f_mem_wen, f_mem_rvalid;
  logic [31:0] f_rsp_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic [3:0]  f_mem_be;
  logic        f_misal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_initiator dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_width(req_width),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misalign_err(misal)
`endif
  );

  lsu_mem_initiator #(.ADDR_W(32), .IO_BASE(32'h0)) dut_flat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_wen(req_wen), .req_width(req_width),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
    .mem_req(f_mem_req), .mem_gnt(f_mem_gnt), .mem_addr(f_mem_addr), .mem_wen(f_mem_wen),
    .mem_be(f_mem_be), .mem_wdata(f_mem_wdata), .mem_rvalid(f_mem_rvalid), .mem_rdata(f_mem_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misalign_err(f_misal)
`endif
  );

`ifndef MISALIGN_TRAP_EN
  assign misal   = 1'b0;
  assign f_misal = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          beats;
    logic [31:0] addr1;
    logic [3:0]  be1;
    logic [3:0]  be2;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          lat;
  } vec_t;

  vec_t vecs [13];

  // Results captured by run_req.
  int          beat_cnt, be_zero, lat_seen;
  logic        got_rsp, misal_seen;
  logic [31:0] rdata_seen;
  logic [31:0] b_addr  [2];
  logic [3:0]  b_be    [2];
  logic [31:0] b_wdata [2];
  logic        b_wen   [2];

  task automatic drive_req(input logic wen, input logic [2:0] width, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic to_main, input logic to_flat);
    @(negedge clk);
    req_wen = wen; req_width = width; req_addr = addr; req_wdata = wdata;
    req_valid = to_main; f_req_valid = to_flat;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; f_req_valid = 1'b0;
  endtask

  // Acts as the memory with immediate grant and one-cycle read latency; returns at the response.
  task automatic run_req(input logic wen, input logic [2:0] width, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1);
    logic pend;
    int   pend_idx;
    pend = 1'b0; pend_idx = 0;
    beat_cnt = 0; be_zero = 0; got_rsp = 1'b0; lat_seen = 0; rdata_seen = '0; misal_seen = 1'b0;
    mem_gnt = 1'b1;
    drive_req(wen, width, addr, wdata, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      mem_rvalid = pend;
      mem_rdata  = pend ? ((pend_idx == 0) ? rd0 : rd1) : 32'h0;
      pend = 1'b0;
      if (mem_req) begin
        if (mem_be == 4'd0) be_zero++;
        if (beat_cnt < 2) begin
          b_addr[beat_cnt] = mem_addr; b_be[beat_cnt] = mem_be;
          b_wdata[beat_cnt] = mem_wdata; b_wen[beat_cnt] = mem_wen;
        end
        if (!mem_wen) begin pend = 1'b1; pend_idx = beat_cnt; end
        beat_cnt++;
      end
      if (rsp_valid) begin
        got_rsp = 1'b1; lat_seen = k + 1; rdata_seen = rsp_rdata; misal_seen = misal;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          e_beats, e_lat;
    logic [31:0] e_rdata;
    logic        e_misal;
    v = vecs[i];
    e_beats = v.beats; e_lat = v.lat; e_rdata = v.exp_rdata; e_misal = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (v.beats == 2) begin e_beats = 0; e_lat = 1; e_rdata = '0; e_misal = 1'b1; end
`endif
    run_req(v.wen, v.width, v.addr, v.wdata, v.rd0, v.rd1);
    check($sformatf("v%0d_rsp_seen", i), 64'(got_rsp), 64'(1));
    check($sformatf("v%0d_latency", i), 64'(lat_seen), 64'(e_lat));
    check($sformatf("v%0d_beats", i), 64'(beat_cnt), 64'(e_beats));
    check($sformatf("v%0d_rdata", i), 64'(rdata_seen), 64'(e_rdata));
    check($sformatf("v%0d_be_zero", i), 64'(be_zero), 64'(0));
    check($sformatf("v%0d_misalign", i), 64'(misal_seen), 64'(e_misal));
    if (e_beats >= 1) begin
      check($sformatf("v%0d_b1_addr_be_wen", i), {27'd0, b_wen[0], b_be[0], b_addr[0]},
            {27'd0, v.wen, v.be1, v.addr1});
      if (v.wen) check($sformatf("v%0d_b1_wdata", i), 64'(b_wdata[0]), 64'(v.exp_wdata));
    end
    if (e_beats == 2) begin
      check($sformatf("v%0d_b2_addr_be_wen", i), {27'd0, b_wen[1], b_be[1], b_addr[1]},
            {27'd0, v.wen, v.be2, v.addr1 + 32'd4});
      if (v.wen) check($sformatf("v%0d_b2_wdata", i), 64'(b_wdata[1]), 64'(v.exp_wdata));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {24'd0, req_ready, rsp_valid, mem_req, mem_wen, mem_be, mem_addr, misal},
          {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0});
    check({tag, "_data"}, {rsp_rdata, mem_wdata}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          wen   width   addr          wdata         rd0           rd1         bts addr1        be1      be2      exp_wdata     exp_rdata     lat
    vecs[0]  = '{1'b0, 3'b000, 32'h00010000, 32'h0,        32'hDEADBEEF, 32'h0,        1, 32'h00010000, 4'b1111, 4'b0000, 32'h0,        32'hDEADBEEF, 3};
    vecs[1]  = '{1'b1, 3'b010, 32'h00010003, 32'h000000A5, 32'h0,        32'h0,        1, 32'h00010000, 4'b1000, 4'b0000, 32'hA5000000, 32'h0,        2};
    vecs[2]  = '{1'b0, 3'b001, 32'h00010003, 32'h0,        32'h80000000, 32'h00000012, 2, 32'h00010000, 4'b1000, 4'b0001, 32'h0,        32'h00001280, 5};
    vecs[3]  = '{1'b0, 3'b101, 32'h00010003, 32'h0,        32'h80112233, 32'h44556692, 2, 32'h00010000, 4'b1000, 4'b0001, 32'h0,        32'h00009280, 5};
    vecs[4]  = '{1'b0, 3'b001, 32'h00010003, 32'h0,        32'h80112233, 32'h44556692, 2, 32'h00010000, 4'b1000, 4'b0001, 32'h0,        32'hFFFF9280, 5};
    vecs[5]  = '{1'b0, 3'b010, 32'h00010001, 32'h0,        32'h0000F000, 32'h0,        1, 32'h00010000, 4'b0010, 4'b0000, 32'h0,        32'hFFFFFFF0, 3};
    vecs[6]  = '{1'b0, 3'b110, 32'h00010002, 32'h0,        32'h00F00000, 32'h0,        1, 32'h00010000, 4'b0100, 4'b0000, 32'h0,        32'h000000F0, 3};
    vecs[7]  = '{1'b1, 3'b001, 32'h00010002, 32'h0000BEEF, 32'h0,        32'h0,        1, 32'h00010000, 4'b1100, 4'b0000, 32'hBEEF0000, 32'h0,        2};
    vecs[8]  = '{1'b1, 3'b000, 32'h00010001, 32'h11223344, 32'h0,        32'h0,        2, 32'h00010000, 4'b1110, 4'b0001, 32'h22334411, 32'h0,        3};
    vecs[9]  = '{1'b0, 3'b000, 32'h00010002, 32'h0,        32'hAABB1111, 32'h2222CCDD, 2, 32'h00010000, 4'b1100, 4'b0011, 32'h0,        32'hCCDDAABB, 5};
    vecs[10] = '{1'b0, 3'b000, 32'hBFC01002, 32'h0,        32'h11223344, 32'h0,        1, 32'hBFC01000, 4'b1111, 4'b0000, 32'h0,        32'h33441122, 3};
    vecs[11] = '{1'b0, 3'b111, 32'h00010004, 32'h0,        32'h01020304, 32'h0,        1, 32'h00010004, 4'b1111, 4'b0000, 32'h0,        32'h01020304, 3};
    vecs[12] = '{1'b0, 3'b001, 32'h00010002, 32'h0,        32'h80011234, 32'h0,        1, 32'h00010000, 4'b1100, 4'b0000, 32'h0,        32'hFFFF8001, 3};

    rst_n = 1'b0;
    req_valid = 1'b0; f_req_valid = 1'b0; req_wen = 1'b0; req_width = 3'b000;
    req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    f_mem_gnt = 1'b1; f_mem_rvalid = 1'b0; f_mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Store wrapping past the top of the address space on the no-I/O-window instance;
    // the default instance sees the same address inside its I/O window.
    begin
      int          fb, mb;
      logic        f_done;
      logic [31:0] fa [2];
      logic [31:0] fw [2];
      logic [3:0]  fbe [2];
      logic [31:0] ma;
      logic [3:0]  mbe;
      fb = 0; mb = 0; f_done = 1'b0; ma = '0; mbe = '0;
      mem_gnt = 1'b1;
      drive_req(1'b1, 3'b000, 32'hFFFFFFFE, 32'h11223344, 1'b1, 1'b1);
      for (int k = 0; k < 10 && !f_done; k++) begin
        if (f_mem_req && fb < 2) begin fa[fb] = f_mem_addr; fw[fb] = f_mem_wdata; fbe[fb] = f_mem_be; end
        if (f_mem_req) fb++;
        if (mem_req) begin ma = mem_addr; mbe = mem_be; mb++; end
        if (f_rsp_valid) f_done = 1'b1;
        else begin @(posedge clk); @(negedge clk); end
      end
      check("wrap_io_beats", 64'(mb), 64'(1));
      check("wrap_io_addr_be", {28'd0, mbe, ma}, {28'd0, 4'b1111, 32'hFFFFFFFC});
      check("wrap_flat_done", 64'(f_done), 64'(1));
`ifdef MISALIGN_TRAP_EN
      check("wrap_flat_trap", {31'd0, f_misal, 31'd0, f_mem_req}, {31'd0, 1'b1, 32'd0});
      check("wrap_flat_beats", 64'(fb), 64'(0));
`else
      check("wrap_flat_beats", 64'(fb), 64'(2));
      check("wrap_flat_b1", {fbe[0], 12'd0, fw[0][31:16], fa[0]}, {4'b1100, 12'd0, 16'h3344, 32'hFFFFFFFC});
      check("wrap_flat_b2", {fbe[1], 12'd0, fw[1][15:0], fa[1]}, {4'b0011, 12'd0, 16'h1122, 32'h00000000});
`endif
      @(posedge clk); @(negedge clk);
    end

    // Grant withheld for five cycles on a byte load, then read data withheld two more.
    mem_gnt = 1'b0;
    drive_req(1'b0, 3'b010, 32'h00010001, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold_c%0d", k), {26'd0, mem_req, req_ready, rsp_valid, mem_be, mem_addr},
            {26'd0, 1'b1, 1'b0, 1'b0, 4'b0010, 32'h00010000});
      @(posedge clk); @(negedge clk);
    end
    mem_gnt = 1'b1;
    check("hold_grant_cycle", {mem_req, mem_be}, {1'b1, 4'b0010});
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("hold_wait_c%0d", k), {mem_req, rsp_valid, req_ready}, 3'b000);
      @(posedge clk); @(negedge clk);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h00008000;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;
    check("hold_rsp", {rsp_valid, rsp_rdata}, {1'b1, 32'hFFFFFF80});
    @(posedge clk); @(negedge clk);
    check("hold_after_rsp", {rsp_valid, req_ready}, 2'b01);

    // Reset pulsed while waiting for read data: outputs revert and no response follows.
    mem_gnt = 1'b1;
    drive_req(1'b0, 3'b000, 32'h00010000, 32'h0, 1'b1, 1'b0);
    check("abort_issue", {mem_req, mem_addr}, {1'b1, 32'h00010000});
    @(posedge clk); @(negedge clk);
    check("abort_in_wait", {mem_req, rsp_valid, req_ready}, 3'b000);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("abort_quiet_c%0d", k), {rsp_valid, mem_req, req_ready}, 3'b001);
      @(posedge clk); @(negedge clk);
    end
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
